// File: rtl/ws2812_chain_driver.sv
// WS2812 chain driver: LED_NUM x 24-bit pixel buffer serialised on demand, then a latch gap.
// Define WS2812_BRIGHTNESS_EN to add the global brightness port and a two-cycle scaled LOAD.
module ws2812_chain_driver #(
    parameter int unsigned CLK_FRE  = 27_000_000,
    parameter int unsigned LED_NUM  = 8,
    parameter int unsigned T1H_NS   = 850,
    parameter int unsigned T1L_NS   = 400,
    parameter int unsigned T0H_NS   = 400,
    parameter int unsigned T0L_NS   = 850,
    parameter int unsigned RESET_US = 80,
    localparam int unsigned AW      = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          ws2812_di
`ifdef WS2812_BRIGHTNESS_EN
    ,
    input  logic [7:0]    brightness
`endif
);

    function automatic int unsigned ns_to_cyc(input int unsigned ns);
        int unsigned c;
        c = (CLK_FRE / 1000) * ns / 1_000_000;
        return (c == 0) ? 1 : c;
    endfunction

    localparam int unsigned T1H_CYC   = ns_to_cyc(T1H_NS);
    localparam int unsigned T1L_CYC   = ns_to_cyc(T1L_NS);
    localparam int unsigned T0H_CYC   = ns_to_cyc(T0H_NS);
    localparam int unsigned T0L_CYC   = ns_to_cyc(T0L_NS);
    localparam int unsigned RST_RAW   = (CLK_FRE / 1_000_000) * RESET_US;
    localparam int unsigned RESET_CYC = (RST_RAW == 0) ? 1 : RST_RAW;
    localparam int unsigned MAX_H     = (T1H_CYC > T0H_CYC) ? T1H_CYC : T0H_CYC;
    localparam int unsigned MAX_L     = (T1L_CYC > T0L_CYC) ? T1L_CYC : T0L_CYC;
    localparam int unsigned MAX_B     = (MAX_H > MAX_L) ? MAX_H : MAX_L;
    localparam int unsigned MAX_CYC   = (MAX_B > RESET_CYC) ? MAX_B : RESET_CYC;
    localparam int unsigned CW        = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] T1H_M1 = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0] T1L_M1 = CW'(T1L_CYC - 1);
    localparam logic [CW-1:0] T0H_M1 = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0] T0L_M1 = CW'(T0L_CYC - 1);
    localparam logic [CW-1:0] RST_M1 = CW'(RESET_CYC - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StHigh, StLow, StLatch} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [23:0]   shift_q, shift_d;
    logic          di_q, di_d;
    logic          busy_q, busy_d;
    logic          done_pend_q, done_pend_d;
    logic          done_q, done_d;
    logic          latch_end;
    logic [23:0]   pix;
    logic [23:0]   mem_q [LED_NUM];

`ifdef WS2812_BRIGHTNESS_EN
    logic load_ph_q, load_ph_d;

    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        return 8'(({9'd0, c} * ({9'd0, b} + 17'd1)) >> 8);
    endfunction
`endif

    // Buffer has no reset; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < LED_NUM)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign pix = mem_q[idx_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        latch_end = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
        load_ph_d = load_ph_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            StLoad: begin
`ifdef WS2812_BRIGHTNESS_EN
                if (!load_ph_q) begin
                    shift_d   = {scale8(pix[23:16], brightness), scale8(pix[15:8], brightness),
                                 scale8(pix[7:0], brightness)};
                    load_ph_d = 1'b1;
                end else begin
                    load_ph_d = 1'b0;
                    bit_d     = 5'd23;
                    cnt_d     = shift_q[23] ? T1H_M1 : T0H_M1;
                    state_d   = StHigh;
                end
`else
                shift_d = pix;
                bit_d   = 5'd23;
                cnt_d   = pix[23] ? T1H_M1 : T0H_M1;
                state_d = StHigh;
`endif
            end
            StHigh: begin
                if (cnt_q == '0) begin
                    state_d = StLow;
                    cnt_d   = shift_q[23] ? T1L_M1 : T0L_M1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StLow: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (bit_q != 5'd0) begin
                    bit_d   = bit_q - 5'd1;
                    shift_d = {shift_q[22:0], 1'b0};
                    cnt_d   = shift_q[22] ? T1H_M1 : T0H_M1;
                    state_d = StHigh;
                end else if (32'(idx_q) < LED_NUM - 1) begin
                    idx_d   = idx_q + AW'(1);
                    state_d = StLoad;
                end else begin
                    cnt_d   = RST_M1;
                    state_d = StLatch;
                end
            end
            StLatch: begin
                if (cnt_q == '0) begin
                    latch_end = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs trail the state by one cycle so every phase keeps its exact length on the pin.
        di_d        = (state_q == StHigh);
        busy_d      = (state_q != StIdle);
        done_pend_d = latch_end;
        done_d      = done_pend_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            di_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
            load_ph_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            di_q        <= di_d;
            busy_q      <= busy_d;
            done_pend_q <= done_pend_d;
            done_q      <= done_d;
`ifdef WS2812_BRIGHTNESS_EN
            load_ph_q   <= load_ph_d;
`endif
        end
    end

    assign ws2812_di = di_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
